// File: rtl/ram_port_arbiter.sv
// Two-master arbiter/sequencer for a shared single-port synchronous-read RAM port.
// Define KANADE32_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed m0 priority.
module ram_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wren,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wren,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [29:0] ram_address,
    output logic [3:0]  ram_byteena,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic        busy
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("ram_port_arbiter: RD_LAT=%0d is outside the legal range 1..4", RD_LAT);
    end

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        win;
    logic        lat_wren;
    logic [2:0]  cnt;
    logic        any_req;
    logic        addr_lsb_unused;

    assign any_req         = m0_req | m1_req;
    assign addr_lsb_unused = ^{m0_addr[1:0], m1_addr[1:0]};

`ifdef KANADE32_ARB_ROUND_ROBIN_EN
    // last_gnt = 1 means m1 was granted last; reset value lets m0 win the first tie.
    logic last_gnt;

    always_comb begin
        if (m0_req && m1_req) win = ~last_gnt;
        else                  win = ~m0_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    last_gnt <= 1'b1;
        else if (state == IDLE && any_req) last_gnt <= win;
    end
`else
    assign win = ~m0_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_wren ? RESP : WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, latency counter and per-master read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner       <= 1'b0;
            lat_wren    <= 1'b0;
            cnt         <= 3'd0;
            ram_address <= '0;
            ram_byteena <= '0;
            ram_data    <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= win;
                        if (win) begin
                            ram_address <= m1_addr[31:2];
                            lat_wren    <= m1_wren;
                            ram_byteena <= m1_wren ? m1_byteen : 4'hF;
                            ram_data    <= m1_wdata;
                        end else begin
                            ram_address <= m0_addr[31:2];
                            lat_wren    <= m0_wren;
                            ram_byteena <= m0_wren ? m0_byteen : 4'hF;
                            ram_data    <= m0_wdata;
                        end
                    end
                end
                ISSUE: cnt <= LAT_INIT;
                WAIT: begin
                    if (cnt == 3'd0) begin
                        if (owner) m1_rdata <= ram_q;
                        else       m0_rdata <= ram_q;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        ram_wren  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                m0_gnt   = ~owner;
                m1_gnt   = owner;
                ram_wren = lat_wren;
            end
            RESP: begin
                m0_rvalid = ~owner;
                m1_rvalid = owner;
            end
            default: ;
        endcase
    end

endmodule
